// File: rtl/montgomery_mul.sv
// montgomery_mul: radix-2 bit-serial Montgomery multiplier.
// Computes A*B*2^-N mod M with one AW-bit addition per cycle over N cycles,
// then one conditional subtraction. Fixed latency of N+2 cycles per start.
module montgomery_mul #(
  parameter int N = 512,
  localparam int AW = N + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    LOOP,
    FINAL
  } state_t;

  state_t state;
  state_t state_next;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  m_reg;
  logic [AW-1:0] bm_reg;
  logic [AW-1:0] c_reg;
  logic [CW-1:0] cnt;

  logic          a_bit;
  logic          q_bit;
  logic [AW-1:0] addend;
  logic [AW:0]   loop_sum;
  logic [AW:0]   final_diff;
  logic          last_iter;

  // Iteration datapath: addend select, full-width sum, and the final
  // subtract whose top bit is the borrow (C < M)
  always_comb begin
    a_bit      = a_reg[0];
    q_bit      = c_reg[0] ^ (a_bit & b_reg[0]);
    addend     = '0;
    case ({a_bit, q_bit})
      2'b10:   addend = AW'(b_reg);
      2'b01:   addend = AW'(m_reg);
      2'b11:   addend = bm_reg;
      default: addend = '0;
    endcase
    loop_sum   = {1'b0, c_reg} + {1'b0, addend};
    final_diff = {1'b0, c_reg} - (AW + 1)'(m_reg);
    last_iter  = (cnt == CW'(N - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> PRE -> LOOP (N cycles) -> FINAL -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PRE;
      PRE:     state_next = LOOP;
      LOOP:    if (last_iter) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand capture, B+M precompute, accumulate-and-halve loop, final reduction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      bm_reg <= '0;
      c_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
            c_reg <= '0;
            cnt   <= '0;
          end
        end
        PRE: begin
          bm_reg <= AW'(b_reg) + AW'(m_reg);
        end
        LOOP: begin
          c_reg <= AW'(loop_sum >> 1);
          a_reg <= a_reg >> 1;
          cnt   <= cnt + CW'(1);
        end
        FINAL: begin
          result <= N'(final_diff[AW] ? {1'b0, c_reg} : final_diff);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul.sv
// tb_montgomery_mul: scoreboard-based bench for montgomery_mul.
// Expected results are queued when an operation is started and popped
// when the done pulse is observed.
`timescale 1ns/1ps
module tb_montgomery_mul;

  localparam int N          = 512;
  localparam int AW         = N + 2;
  localparam int TIMEOUT    = N + 50;
  localparam int NUM_RANDOM = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;
  logic         busy;

  int n_checks   = 0;
  int n_pass     = 0;
  int done_count = 0;
  int acc_viol   = 0;

  logic [N-1:0] sb[$];
  logic [N-1:0] cur_m = '0;
  logic [N-1:0] all_ones;

  montgomery_mul #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Counts done pulses and watches that the accumulator stays below 2M
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (busy === 1'b1 && dut.c_reg >= {1'b0, cur_m, 1'b0}) acc_viol++;
  end

  // Reference: reduce A*B mod M, then halve N times modulo M
  function automatic logic [N-1:0] ref_mont(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [2*N-1:0] prod;
    logic [2*N-1:0] red;
    logic [N:0]     x;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    red  = prod % {{N{1'b0}}, m};
    x    = red[N:0];
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = (x + {1'b0, m}) >> 1;
      else      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Caller must be at a negedge; returns at the first negedge after the start edge
  task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] m, input logic [N-1:0] expv);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    cur_m = m;
    sb.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = number of clock edges from the start edge to the done cycle
  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    in_a  = '0;
    in_b  = '0;
    in_m  = '0;
    start = 1'b0;
    rst   = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (result !== '0) $display("[TB] FAIL reset_result got %h want 0", result);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    logic [N-1:0] a_tab[3];
    logic [N-1:0] b_tab[3];
    logic [N-1:0] e_tab[3];
    logic [N-1:0] expv;
    int lat;
    bit ok;
    a_tab = '{N'(2), all_ones - N'(1), N'(0)};
    b_tab = '{N'(3), all_ones - N'(1), all_ones - N'(1)};
    e_tab = '{N'(6), N'(1), N'(0)};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_start(a_tab[c], b_tab[c], all_ones, e_tab[c]);
      n_checks++;
      if (busy !== 1'b1) $display("[TB] FAIL ident%0d_busy_running got %b want 1", c, busy);
      else n_pass++;
      wait_done(lat, ok);
      n_checks++;
      if (!ok) $display("[TB] FAIL ident%0d_timeout got no done want done within %0d", c, TIMEOUT);
      else n_pass++;
      n_checks++;
      if (sb.size() == 0) $display("[TB] FAIL ident%0d_scoreboard got empty queue want entry", c);
      else begin
        expv = sb.pop_front();
        if (result !== expv) $display("[TB] FAIL ident%0d_result got %h want %h", c, result, expv);
        else n_pass++;
      end
      n_checks++;
      if (lat != N + 2) $display("[TB] FAIL ident%0d_latency got %0d want %0d", c, lat, N + 2);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("[TB] FAIL ident%0d_busy_done got %b want 0", c, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("[TB] FAIL ident%0d_done_width got %b want 0", c, done);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    logic [N-1:0] expv;
    int lat;
    int dc0;
    @(negedge clk);
    dc0 = done_count;
    drive_start(N'(11), N'(13), all_ones, N'(143));
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (lat == 100) begin
        start = 1'b1;
        in_a  = N'(3);
        in_b  = N'(3);
        in_m  = N'(7);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) $display("[TB] FAIL ignored_timeout got no done want done within %0d", TIMEOUT);
    else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("[TB] FAIL ignored_scoreboard got empty queue want entry");
    else begin
      expv = sb.pop_front();
      if (result !== expv) $display("[TB] FAIL ignored_result got %h want %h", result, expv);
      else n_pass++;
    end
    repeat (N + 10) @(negedge clk);
    n_checks++;
    if (done_count - dc0 != 1) $display("[TB] FAIL ignored_done_count got %0d want 1", done_count - dc0);
    else n_pass++;
  endtask

  task automatic test_abort_back_to_back();
    logic [N-1:0] expv;
    int lat;
    int dc0;
    bit ok;
    @(negedge clk);
    dc0 = done_count;
    drive_start(N'(9), N'(9), all_ones, N'(81));
    repeat (199) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (result !== '0) $display("[TB] FAIL abort_result got %h want 0", result);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive_start(N'(5), N'(7), all_ones, N'(35));
    wait_done(lat, ok);
    n_checks++;
    if (!ok || sb.size() == 0) $display("[TB] FAIL b2b_first got done=%b queue=%0d want done with entry", done, sb.size());
    else begin
      expv = sb.pop_front();
      if (result !== expv) $display("[TB] FAIL b2b_first_result got %h want %h", result, expv);
      else n_pass++;
    end
    drive_start(N'(6), N'(6), all_ones, N'(36));
    wait_done(lat, ok);
    n_checks++;
    if (!ok || sb.size() == 0) $display("[TB] FAIL b2b_second got done=%b queue=%0d want done with entry", done, sb.size());
    else begin
      expv = sb.pop_front();
      if (result !== expv) $display("[TB] FAIL b2b_second_result got %h want %h", result, expv);
      else n_pass++;
    end
    n_checks++;
    if (lat != N + 2) $display("[TB] FAIL b2b_latency got %0d want %0d", lat, N + 2);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_count - dc0 != 2) $display("[TB] FAIL b2b_done_count got %0d want 2", done_count - dc0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] expv;
    int lat;
    bit ok;
    acc_viol = 0;
    for (int r = 0; r < NUM_RANDOM; r++) begin
      m    = rand_wide();
      m[0] = 1'b1;
      if (r % 4 == 0) m[N-1] = 1'b1;
      a = rand_wide() % m;
      b = rand_wide() % m;
      @(negedge clk);
      drive_start(a, b, m, ref_mont(a, b, m));
      wait_done(lat, ok);
      n_checks++;
      if (!ok || sb.size() == 0) $display("[TB] FAIL rand%0d got done=%b queue=%0d want done with entry", r, done, sb.size());
      else begin
        expv = sb.pop_front();
        if (result !== expv) $display("[TB] FAIL rand%0d_result got %h want %h", r, result, expv);
        else n_pass++;
      end
    end
    n_checks++;
    if (acc_viol != 0) $display("[TB] FAIL acc_bound got %0d violations want 0", acc_viol);
    else n_pass++;
  endtask

  // Test sequence
  initial begin
    all_ones = '1;
    test_reset();
    test_identity();
    test_ignored_start();
    test_abort_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
